// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the serial ALU and its byte slice.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_slice8.sv
// Combinational 8-bit add/logic slice; SUB/SBC/CP invert B here so the caller only supplies carry-in.
// CP yields the subtraction result; the caller substitutes A for the visible result.
module alu_slice8
  import alu_pkg::*;
(
  input  logic [7:0] i_A,
  input  logic [7:0] i_B,
  input  logic       i_Cin,
  input  logic [2:0] i_Opcode,
  output logic [7:0] o_Result,
  output logic       o_Cout,
  output logic       o_HalfCarry
);

  logic       w_Invert;
  logic [7:0] w_B;
  logic [4:0] w_Lo;
  logic [4:0] w_Hi;

  assign w_Invert = (i_Opcode == OP_SUB) || (i_Opcode == OP_SBC) || (i_Opcode == OP_CP);
  assign w_B      = w_Invert ? ~i_B : i_B;

  // Split at the nybble boundary so the bit-3 carry is directly available.
  assign w_Lo = {1'b0, i_A[3:0]} + {1'b0, w_B[3:0]} + {4'b0000, i_Cin};
  assign w_Hi = {1'b0, i_A[7:4]} + {1'b0, w_B[7:4]} + {4'b0000, w_Lo[4]};

  assign o_HalfCarry = w_Lo[4];
  assign o_Cout      = w_Hi[4];

  always_comb begin
    case (i_Opcode)
      OP_AND:  o_Result = i_A & i_B;
      OP_XOR:  o_Result = i_A ^ i_B;
      OP_OR:   o_Result = i_A | i_B;
      default: o_Result = {w_Hi[3:0], w_Lo[3:0]};
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// DATA_W-bit ALU iterating one 8-bit slice LSB-byte-first, DATA_W/8 cycles per operation.
// Start is taken only when idle; o_Done pulses one cycle after the last slice, with o_Busy already low.
module serial_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  input  logic [2:0]        i_Opcode,
  input  logic [3:0]        i_F,
  input  logic              i_KeepZ,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [DATA_W-1:0] o_Result,
  output logic [3:0]        o_F
);

  localparam int NSLICE = DATA_W / 8;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_t            r_State;
  state_t            w_NextState;
  logic [CNT_W-1:0]  r_Cnt;
  logic [DATA_W-1:0] r_A;
  logic [DATA_W-1:0] r_B;
  logic [DATA_W-1:0] r_Sum;
  logic [DATA_W-1:0] r_Result;
  logic [2:0]        r_Op;
  logic [3:0]        r_F;
  logic              r_Carry;
  logic              r_OldZ;
  logic              r_KeepZ;
  logic              r_Done;

  logic              w_Accept;
  logic              w_Last;
  logic              w_IsSub;
  logic              w_IsArith;
  logic [IDX_W-1:0]  w_Base;
  logic [7:0]        w_ByteRes;
  logic              w_Cout;
  logic              w_HalfCarry;
  logic [DATA_W-1:0] w_SumNext;
  logic [3:0]        w_FNext;
  logic              w_unused_flags;

  assign w_unused_flags = ^i_F[FLAG_N:FLAG_H];

  assign w_Last    = (r_Cnt == LAST_CNT);
  assign w_Base    = IDX_W'({r_Cnt, 3'b000});
  assign w_IsSub   = (r_Op == OP_SUB) || (r_Op == OP_SBC) || (r_Op == OP_CP);
  assign w_IsArith = ~r_Op[2] || (r_Op == OP_CP);

  alu_slice8 u_slice (
    .i_A         (r_A[w_Base +: 8]),
    .i_B         (r_B[w_Base +: 8]),
    .i_Cin       (r_Carry),
    .i_Opcode    (r_Op),
    .o_Result    (w_ByteRes),
    .o_Cout      (w_Cout),
    .o_HalfCarry (w_HalfCarry)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_State <= S_IDLE;
    else         r_State <= w_NextState;
  end

  always_comb begin
    w_NextState = r_State;
    w_Accept    = 1'b0;
    case (r_State)
      S_IDLE: if (i_Start) begin
        w_NextState = S_RUN;
        w_Accept    = 1'b1;
      end
      S_RUN:   if (w_Last) w_NextState = S_IDLE;
      default: w_NextState = S_IDLE;
    endcase
  end

  // Full-width sum including the byte being produced this cycle; Z and the final result come from it.
  always_comb begin
    w_SumNext               = r_Sum;
    w_SumNext[w_Base +: 8]  = w_ByteRes;
    w_FNext                 = 4'b0000;
    w_FNext[FLAG_Z]         = r_KeepZ ? r_OldZ : (w_SumNext == '0);
    w_FNext[FLAG_N]         = w_IsSub;
    w_FNext[FLAG_H]         = w_IsArith ? (w_HalfCarry ^ w_IsSub) : (r_Op == OP_AND);
    w_FNext[FLAG_C]         = w_IsArith && (w_Cout ^ w_IsSub);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Cnt    <= '0;
      r_A      <= '0;
      r_B      <= '0;
      r_Sum    <= '0;
      r_Result <= '0;
      r_Op     <= OP_ADD;
      r_F      <= 4'b0000;
      r_Carry  <= 1'b0;
      r_OldZ   <= 1'b0;
      r_KeepZ  <= 1'b0;
      r_Done   <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      if (w_Accept) begin
        r_A     <= i_A;
        r_B     <= i_B;
        r_Op    <= i_Opcode;
        r_OldZ  <= i_F[FLAG_Z];
        r_KeepZ <= i_KeepZ;
        r_Cnt   <= '0;
        r_Sum   <= '0;
        // SUB/CP start with carry 1 (two's complement); ADC uses C; SBC uses ~C as the inverted borrow.
        r_Carry <= i_Opcode[1] ^ (i_Opcode[0] & i_F[FLAG_C] & ~i_Opcode[2]);
      end else if (r_State == S_RUN) begin
        r_Sum   <= w_SumNext;
        r_Carry <= w_Cout;
        r_Cnt   <= r_Cnt + 1'b1;
        if (w_Last) begin
          r_Done   <= 1'b1;
          r_Result <= (r_Op == OP_CP) ? r_A : w_SumNext;
          r_F      <= w_FNext;
        end
      end
    end
  end

  assign o_Busy   = (r_State == S_RUN);
  assign o_Done   = r_Done;
  assign o_Result = r_Result;
  assign o_F      = r_F;

endmodule
